muldiv: RTL and testbench

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module   : muldiv
// Purpose  : Iterative multiply / divide / multiply-accumulate unit for the
//            EX stage. One shift-add or restoring-divide step per cycle,
//            one cycle of sign/accumulate fix-up, then a one-cycle ready
//            pulse with the {HI,LO} result.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               divzero_o,
    output logic               stallreq_o
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_divzero;
    logic [2*WIDTH-1:0]   r_result;

    // Latched operation attributes
    logic                 r_is_div;
    logic                 r_acc_en;
    logic                 r_sub;
    logic                 r_neg_res;
    logic                 r_neg_dvd;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH-1:0]   r_work;
    logic [2*WIDTH-1:0]   r_acc;

    // Latch-time decode and operand magnitudes
    logic                 w_is_div_in;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    // Iteration step results
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;

    // Fix-up results
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_fix;

    // Operand decode: signed ops work on magnitudes; the most negative value
    // maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        w_is_div_in = ~op_i[2] & op_i[1];
        w_a_neg     = op_i[0] & opdata1_i[WIDTH-1];
        w_b_neg     = op_i[0] & opdata2_i[WIDTH-1];
        w_a_mag     = w_a_neg ? (-opdata1_i) : opdata1_i;
        w_b_mag     = w_b_neg ? (-opdata2_i) : opdata2_i;
    end

    // One shift-add multiply step and one restoring divide step. r_work holds
    // {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum   = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_m} : '0);
        w_mul_next  = {w_mul_sum, r_work[WIDTH-1:1]};
        w_div_shift = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_m};
        w_div_ge    = (w_div_shift >= {1'b0, r_m});
        w_div_next  = w_div_ge ? {w_div_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1}
                               : {w_div_shift[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};
    end

    // Final sign correction and optional accumulate into {hi,lo}
    always_comb begin
        w_prod = r_neg_res ? (-r_work) : r_work;
        w_quot = r_neg_res ? (-r_work[WIDTH-1:0]) : r_work[WIDTH-1:0];
        w_rem  = r_neg_dvd ? (-r_work[2*WIDTH-1:WIDTH]) : r_work[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_fix = {w_rem, w_quot};
        end else if (r_acc_en) begin
            w_fix = r_sub ? (r_acc - w_prod) : (r_acc + w_prod);
        end else begin
            w_fix = w_prod;
        end
    end

    // Control FSM with datapath registers; annul wins over everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_divzero <= 1'b0;
            r_result  <= '0;
            r_is_div  <= 1'b0;
            r_acc_en  <= 1'b0;
            r_sub     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_m       <= '0;
            r_work    <= '0;
            r_acc     <= '0;
        end else if (annul_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (start_i) begin
                        r_is_div  <= w_is_div_in;
                        r_acc_en  <= op_i[2];
                        r_sub     <= op_i[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_dvd <= w_a_neg;
                        r_m       <= w_is_div_in ? w_b_mag : w_a_mag;
                        r_work    <= {{WIDTH{1'b0}}, (w_is_div_in ? w_a_mag : w_b_mag)};
                        r_acc     <= {hi_i, lo_i};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_is_div_in && (opdata2_i == '0)) begin
                            // Divide by zero completes immediately with a flag
                            r_state   <= S_DONE;
                            r_ready   <= 1'b1;
                            r_result  <= '0;
                            r_divzero <= 1'b1;
                        end else begin
                            r_state <= w_is_div_in ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (!start_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_work <= (r_state == S_DIV) ? w_div_next : w_mul_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!start_i) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result  <= w_fix;
                        r_divzero <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign busy_o     = r_busy;
    assign divzero_o  = r_divzero;
    assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv
// Purpose  : Directed-vector scoreboard bench for muldiv (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_i = 1'b0;
    logic [2:0]     op_i = '0;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic [W-1:0]   hi_i = '0;
    logic [W-1:0]   lo_i = '0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;
    logic           divzero_o;
    logic           stallreq_o;

    typedef struct packed {
        logic [63:0] res;
        logic        dz;
        logic [31:0] at_edge;
    } exp_t;

    exp_t        sb_q[$];
    string       name_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [63:0] last_res = '0;

    muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .divzero_o  (divzero_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; edge numbers locate the sampling edge of ready_o
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever ready_o is seen (sampled at negedge)
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (ready_o) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready_o=1 with result %h, expected no pending op", result_o);
                end else begin
                    e  = sb_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_result"}, result_o, e.res);
                    check({nm, "_divzero"}, 64'(divzero_o), 64'(e.dz));
                    // ready_o seen now is captured by the next rising edge
                    check({nm, "_latency_edge"}, 64'(cyc + 1), 64'(e.at_edge));
                end
            end
        end
    end

    // Issue one op, push expectation, scramble inputs after acceptance,
    // hold start_i until ready_o then drop it.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [63:0] exp_res, input logic exp_dz, input int lat);
        bit got;
        @(negedge clk);
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        hi_i      = hi;
        lo_i      = lo;
        start_i   = 1'b1;
        sb_q.push_back('{res: exp_res, dz: exp_dz, at_edge: 32'(cyc + 1 + lat)});
        name_q.push_back(name);
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        hi_i      = $urandom;
        lo_i      = $urandom;
        op_i      = 3'($urandom);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                break;
            end else if (i == 0) begin
                check({name, "_stallreq_busy"}, 64'(stallreq_o), 64'd1);
            end
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready_o in 100 cycles, expected ready_o", name);
        end else begin
            check({name, "_stallreq_done"}, 64'(stallreq_o), 64'd0);
            last_res = exp_res;
        end
        start_i = 1'b0;
    endtask

    initial begin : stim
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", result_o, 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_divzero", 64'(divzero_o), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        run_op("mult_neg2x3",  3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0,
               64'hFFFFFFFF_FFFFFFFA, 1'b0, 34);
        run_op("maddu_carry",  3'b100, 32'h00000002, 32'h00000003, 32'h0, 32'hFFFFFFFF,
               64'h00000001_00000005, 1'b0, 34);
        run_op("div_m7_by_2",  3'b011, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0,
               64'hFFFFFFFF_FFFFFFFD, 1'b0, 34);
        run_op("div_min_by_m1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
               64'h00000000_80000000, 1'b0, 34);
        run_op("divu_by_zero", 3'b010, 32'h12345678, 32'h00000000, 32'h0, 32'h0,
               64'h0, 1'b1, 1);
        repeat (2) @(negedge clk);
        check("divzero_hold", 64'(divzero_o), 64'd1);
        run_op("multu_max",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
               64'hFFFFFFFE_00000001, 1'b0, 34);
        run_op("divu_100_by_7", 3'b010, 32'd100, 32'd7, 32'h0, 32'h0,
               64'h00000002_0000000E, 1'b0, 34);
        run_op("msub_signed",  3'b111, 32'd3, 32'hFFFFFFFC, 32'h0, 32'd10,
               64'h00000000_00000016, 1'b0, 34);
        run_op("madd_signed",  3'b101, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFF_FFFFFFE6, 1'b0, 34);
        run_op("msubu_wrap",   3'b110, 32'd2, 32'd3, 32'h0, 32'd5,
               64'hFFFFFFFF_FFFFFFFF, 1'b0, 34);
        run_op("div_7_by_m2",  3'b011, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
               64'h00000001_FFFFFFFD, 1'b0, 34);
        run_op("div_by_zero",  3'b011, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h0,
               64'h0, 1'b1, 1);
        run_op("mult_min_sq",  3'b001, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
               64'h40000000_00000000, 1'b0, 34);

        // Annul at iteration 10 of a MULTU, annul also beating a held start_i
        @(negedge clk);
        op_i = 3'b000; opdata1_i = 32'd5; opdata2_i = 32'd6; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_stallreq", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result_hold", result_o, last_res);
        @(negedge clk);
        check("annul_over_start", 64'(busy_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        run_op("multu_7x9",    3'b000, 32'd7, 32'd9, 32'h0, 32'h0, 64'd63, 1'b0, 34);

        // start_i dropped mid-divide aborts without a result
        @(negedge clk);
        op_i = 3'b010; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (6) @(negedge clk);
        check("drop_busy_before", 64'(busy_o), 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        check("drop_busy_after", 64'(busy_o), 64'd0);
        check("drop_result_hold", result_o, last_res);
        run_op("divu_9_by_3",  3'b010, 32'd9, 32'd3, 32'h0, 32'h0,
               64'h00000000_00000003, 1'b0, 34);

        // Asynchronous reset mid-operation, then accept on the first edge after release
        @(negedge clk);
        op_i = 3'b000; opdata1_i = 32'd11; opdata2_i = 32'd13; start_i = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_result", result_o, 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        last_res = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        run_op("multu_after_rst", 3'b000, 32'd3, 32'd5, 32'h0, 32'h0, 64'd15, 1'b0, 34);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion by 500000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
